// File: rtl/accel_seg_display_if.sv
// rtl/accel_seg_display_if.sv - sample handshake bundle for accel_seg_display
interface accel_seg_display_if;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/accel_seg_display.sv
// rtl/accel_seg_display.sv - signed sample to sign+3 BCD digits on a muxed 7-segment display
// Optional leading-zero blanking: define ACCEL_SEG_LZB_EN.
module accel_seg_display #(
    parameter int unsigned SAT_MAX = 999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accel_seg_display_if.slave   smp_if,
    input  logic [1:0]           array_i,
    output logic [3:0]           an_o,
    output logic [6:0]           seg_o,
    output logic                 dp_o
);

    localparam logic [11:0] SAT       = 12'(SAT_MAX);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] smp_q;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  bin_q, bin_d;
    logic [3:0]  cnt_q;
    logic        sign_q, ovf_nxt_q;
    logic [3:0]  d2_q, d1_q, d0_q;
    logic        neg_q, ovf_q;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [11:0] mag;
    logic        sat;
    logic [21:0] dd_tmp;
    logic        blank_d2, blank_d1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] adj(input logic [3:0] n);
        adj = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (smp_if.sample_valid) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: if (cnt_q == 4'd1) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        smp_if.sample_ready = (state_q == IDLE);
    end

    // |sample| as 12-bit unsigned, so -2048 becomes 2048 and saturates
    always_comb begin
        mag    = smp_q[11] ? (~smp_q + 12'd1) : smp_q;
        sat    = (mag > SAT);
        dd_tmp = {adj(bcd_q[11:8]), adj(bcd_q[7:4]), adj(bcd_q[3:0]), bin_q};
        bcd_d  = dd_tmp[20:9];
        bin_d  = {dd_tmp[8:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ovf_nxt_q <= 1'b0;
            d2_q      <= '0;
            d1_q      <= '0;
            d0_q      <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (smp_if.sample_valid) smp_q <= smp_if.sample;
                LOAD: begin
                    sign_q    <= smp_q[11];
                    ovf_nxt_q <= sat;
                    bin_q     <= sat ? SAT[9:0] : mag[9:0];
                    bcd_q     <= '0;
                    cnt_q     <= 4'd10;
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: begin
                    d2_q  <= bcd_q[11:8];
                    d1_q  <= bcd_q[7:4];
                    d0_q  <= bcd_q[3:0];
                    neg_q <= sign_q;
                    ovf_q <= ovf_nxt_q;
                end
                default: ;
            endcase
        end
    end

`ifdef ACCEL_SEG_LZB_EN
    assign blank_d2 = (d2_q == 4'd0);
    assign blank_d1 = (d2_q == 4'd0) && (d1_q == 4'd0);
`else
    assign blank_d2 = 1'b0;
    assign blank_d1 = 1'b0;
`endif

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (array_i)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = glyph(d0_q);
                dp_d  = ~ovf_q;
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = blank_d1 ? SEG_BLANK : glyph(d1_q);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = blank_d2 ? SEG_BLANK : glyph(d2_q);
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_accel_seg_display.sv
// tb/tb_accel_seg_display.sv - directed self-checking bench for accel_seg_display
module tb_accel_seg_display;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G7 = 7'b1111000, G9 = 7'b0010000;
    localparam logic [6:0] BLK = 7'b1111111, MIN = 7'b0111111;
`ifdef ACCEL_SEG_LZB_EN
    localparam logic [6:0] Z_LEAD = BLK;
`else
    localparam logic [6:0] Z_LEAD = G0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] array_i = 2'd0;
    logic [3:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;
    int         total = 0;
    int         bad = 0;

    accel_seg_display_if u_if ();

    accel_seg_display u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .smp_if  (u_if.slave),
        .array_i (array_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!u_if.sample_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!u_if.sample_ready) chk("ready_timeout", 32'(u_if.sample_ready), 32'd1);
    endtask

    task automatic send(input logic [11:0] s);
        int n = 0;
        wait_ready();
        u_if.sample       = s;
        u_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        u_if.sample_valid = 1'b0;
        while (!u_if.sample_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_low_cycles", 32'(n), 32'd12);
    endtask

    task automatic show(input string tag, input logic [1:0] a, input logic [3:0] ean,
                        input logic [6:0] eseg, input logic edp);
        array_i = a;
        @(posedge clk); #1;
        chk({tag, "_an"},  32'(an_o),  32'(ean));
        chk({tag, "_seg"}, 32'(seg_o), 32'(eseg));
        chk({tag, "_dp"},  32'(dp_o),  32'(edp));
    endtask

    initial begin
        u_if.sample       = '0;
        u_if.sample_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_an",    32'(an_o),  32'hF);
        chk("rst_seg",   32'(seg_o), 32'h7F);
        chk("rst_dp",    32'(dp_o),  32'd1);
        chk("rst_ready", 32'(u_if.sample_ready), 32'd1);
        rst_n = 1'b1;
        show("first", 2'd0, 4'b1110, G0, 1'b1);

        send(12'd123);
        show("p123_d0", 2'd0, 4'b1110, G3,  1'b1);
        show("p123_d1", 2'd1, 4'b1101, G2,  1'b1);
        show("p123_d2", 2'd2, 4'b1011, G1,  1'b1);
        show("p123_d3", 2'd3, 4'b0111, BLK, 1'b1);

        send(12'hFD3);
        show("m45_d0", 2'd0, 4'b1110, G5,     1'b1);
        show("m45_d1", 2'd1, 4'b1101, G4,     1'b1);
        show("m45_d2", 2'd2, 4'b1011, Z_LEAD, 1'b1);
        show("m45_d3", 2'd3, 4'b0111, MIN,    1'b1);

        send(12'h7FF);
        show("p2047_d0", 2'd0, 4'b1110, G9,  1'b0);
        show("p2047_d1", 2'd1, 4'b1101, G9,  1'b1);
        show("p2047_d2", 2'd2, 4'b1011, G9,  1'b1);
        show("p2047_d3", 2'd3, 4'b0111, BLK, 1'b1);

        send(12'h800);
        show("m2048_d0", 2'd0, 4'b1110, G9,  1'b0);
        show("m2048_d2", 2'd2, 4'b1011, G9,  1'b1);
        show("m2048_d3", 2'd3, 4'b0111, MIN, 1'b1);

        // Held-valid retry: second sample offered from k+5 must wait for k+13
        array_i = 2'd0;
        wait_ready();
        u_if.sample       = 12'd12;
        u_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        u_if.sample_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        u_if.sample       = 12'd7;
        u_if.sample_valid = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("hold_ready_k11", 32'(u_if.sample_ready), 32'd0);
        @(posedge clk); #1;
        chk("hold_ready_k12", 32'(u_if.sample_ready), 32'd1);
        chk("hold_seg_k12",   32'(seg_o), 32'(G9));
        chk("hold_dp_k12",    32'(dp_o),  32'd0);
        @(posedge clk); #1;
        u_if.sample_valid = 1'b0;
        chk("hold_seg_k13",   32'(seg_o), 32'(G2));
        chk("hold_dp_k13",    32'(dp_o),  32'd1);
        chk("hold_ready_k13", 32'(u_if.sample_ready), 32'd0);
        wait_ready();
        show("p7_d0", 2'd0, 4'b1110, G7,  1'b1);
        show("p7_d1", 2'd1, 4'b1101, Z_LEAD, 1'b1);
        show("p7_d3", 2'd3, 4'b0111, BLK, 1'b1);

        // Reset in the middle of a -500 conversion
        wait_ready();
        u_if.sample       = 12'hE0C;
        u_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        u_if.sample_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an",    32'(an_o),  32'hF);
        chk("mid_rst_seg",   32'(seg_o), 32'h7F);
        chk("mid_rst_dp",    32'(dp_o),  32'd1);
        chk("mid_rst_ready", 32'(u_if.sample_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        show("post_rst_d0", 2'd0, 4'b1110, G0,     1'b1);
        show("post_rst_d1", 2'd1, 4'b1101, Z_LEAD, 1'b1);
        show("post_rst_d2", 2'd2, 4'b1011, Z_LEAD, 1'b1);
        show("post_rst_d3", 2'd3, 4'b0111, BLK,    1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
